// File: rtl/clock_ctrl_pkg.sv
// Shared definitions for the clock/alarm control front end: mode encoding,
// button indices, field ordering and default timing values.
package clock_ctrl_pkg;

    typedef enum logic [2:0] {
        CLOCK  = 3'd0,
        ADJ_TH = 3'd1,
        ADJ_TM = 3'd2,
        ADJ_AH = 3'd3,
        ADJ_AM = 3'd4,
        ADJ_S  = 3'd5
    } mode_e;

    localparam int NUM_BTNS = 5;
    localparam int BTN_C    = 0;
    localparam int BTN_L    = 1;
    localparam int BTN_R    = 2;
    localparam int BTN_U    = 3;
    localparam int BTN_D    = 4;

    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned DEF_TIMEOUT_CYCLES  = 0;

    // Field order for right-button stepping: TH -> TM -> AH -> AM -> S -> TH
    function automatic mode_e next_field(input mode_e m);
        case (m)
            ADJ_TH:  return ADJ_TM;
            ADJ_TM:  return ADJ_AH;
            ADJ_AH:  return ADJ_AM;
            ADJ_AM:  return ADJ_S;
            ADJ_S:   return ADJ_TH;
            default: return m;
        endcase
    endfunction

    function automatic mode_e prev_field(input mode_e m);
        case (m)
            ADJ_TH:  return ADJ_S;
            ADJ_TM:  return ADJ_TH;
            ADJ_AH:  return ADJ_TM;
            ADJ_AM:  return ADJ_AH;
            ADJ_S:   return ADJ_AM;
            default: return m;
        endcase
    endfunction

    // One-hot enables packed as {TH, TM, AH, AM, S}
    function automatic logic [4:0] field_en(input mode_e m);
        case (m)
            ADJ_TH:  return 5'b10000;
            ADJ_TM:  return 5'b01000;
            ADJ_AH:  return 5'b00100;
            ADJ_AM:  return 5'b00010;
            ADJ_S:   return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchroniser + counter debouncer for one raw push-button; emits a registered
// single-cycle press pulse on each accepted 0->1 transition.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic level,
    output logic press
);

    localparam logic [23:0] CNT_LAST = 24'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [23:0]            cnt_q;
    logic                   stable_q;
    logic                   prev_q;
    logic                   press_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            press_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_in};
            prev_q  <= stable_q;
            press_q <= stable_q & ~prev_q;
            // Any return to the accepted level restarts the stability window
            if (synced == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= synced;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 24'd1;
            end
        end
    end

    assign level = stable_q;
    assign press = press_q;

endmodule

// File: rtl/button_mode_ctrl.sv
// Button front end for the clock/alarm top: five conditioned buttons drive the
// mode FSM, one-hot field enables, up/down pulses and the idle auto-return.
module button_mode_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_c,
    input  logic btn_l,
    input  logic btn_r,
    input  logic btn_u,
    input  logic btn_d,
    output logic adjust,
    output logic ENTH,
    output logic ENTM,
    output logic ENAH,
    output logic ENAM,
    output logic ENS,
    output logic up,
    output logic down
);

    localparam logic [31:0] TIMEOUT    = 32'(TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_ev;

    assign btn_raw = {btn_d, btn_u, btn_r, btn_l, btn_c};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        button_debouncer #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .btn_in(btn_raw[i]),
            .level (),
            .press (btn_ev[i])
        );
    end

    mode_e       state_q, state_d;
    logic [31:0] idle_q, idle_d;
    logic [4:0]  en_q;
    logic        adjust_q, up_q, down_q;
    logic        up_d, down_d;
    logic        ev_c, ev_l, ev_r, ev_u, ev_d, any_ev;

    assign ev_c   = btn_ev[BTN_C];
    assign ev_l   = btn_ev[BTN_L];
    assign ev_r   = btn_ev[BTN_R];
    assign ev_u   = btn_ev[BTN_U];
    assign ev_d   = btn_ev[BTN_D];
    assign any_ev = |btn_ev;

    always_comb begin
        state_d = state_q;
        idle_d  = '0;
        up_d    = 1'b0;
        down_d  = 1'b0;
        if (state_q == CLOCK) begin
            if (ev_c) state_d = ADJ_TH;
        end else begin
            // Pulses are gated by the pre-transition state
            up_d   = ev_u & ~ev_d;
            down_d = ev_d & ~ev_u;
            if (ev_c)                state_d = CLOCK;
            else if (ev_r && !ev_l)  state_d = next_field(state_q);
            else if (ev_l && !ev_r)  state_d = prev_field(state_q);
            else if (TIMEOUT_EN && !any_ev && idle_q == TIMEOUT) state_d = CLOCK;
            if (TIMEOUT_EN && !any_ev && state_d == state_q) idle_d = idle_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CLOCK;
            idle_q   <= '0;
            en_q     <= '0;
            adjust_q <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            en_q     <= field_en(state_d);
            adjust_q <= (state_d != CLOCK);
            up_q     <= up_d;
            down_q   <= down_d;
        end
    end

    assign {ENTH, ENTM, ENAH, ENAM, ENS} = en_q;
    assign adjust = adjust_q;
    assign up     = up_q;
    assign down   = down_q;

endmodule

// File: doc/button_mode_ctrl.md
Name: button_mode_ctrl

Overview:
- Front-end control source for the clock/alarm top level; the producing side of its control interface.
- Conditions five raw push-buttons (synchronise, debounce, edge-detect) and runs a mode FSM.
- Drives `adjust`, one-hot field enables (`ENTH`, `ENTM`, `ENAH`, `ENAM`, `ENS`) and single-cycle `up`/`down` pulses, which the top level consumes directly.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per button input (min 2).
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed to accept a new button level (5 ms at 100 MHz); range 1..2^24-1.
- TIMEOUT_CYCLES, 0: idle cycles in an adjust state before auto-return to CLOCK; 0 disables; 32-bit counter.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  asynchronous, active-low reset.
- btn_c  in  1  raw centre button (async): enter/exit adjust.
- btn_l  in  1  raw left button (async): previous field.
- btn_r  in  1  raw right button (async): next field.
- btn_u  in  1  raw up button (async): increment.
- btn_d  in  1  raw down button (async): decrement.
- adjust  out  1  high in every non-CLOCK state.
- ENTH  out  1  time-hours field selected.
- ENTM  out  1  time-minutes field selected.
- ENAH  out  1  alarm-hours field selected.
- ENAM  out  1  alarm-minutes field selected.
- ENS  out  1  seconds field selected.
- up  out  1  one-cycle increment pulse.
- down  out  1  one-cycle decrement pulse.

Behaviour:
- Reset (rst=0, async): all outputs 0; FSM in CLOCK; synchronisers, debounced levels and counters cleared to 0; takes effect immediately, including mid-debounce or mid-timeout.
- Per-button conditioning:
  - SYNC_STAGES-flop synchroniser.
  - Debounce counter resets to 0 whenever the synchronised level equals the stable level; otherwise it increments. When it reaches DEBOUNCE_CYCLES, the stable level takes the synchronised level and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are never accepted.
  - Press event = stable 0->1 transition, registered, exactly one cycle. No event on release.
  - Latency: a clean step on btn_x yields its press event SYNC_STAGES+DEBOUNCE_CYCLES+1 clk edges later.
- FSM states: CLOCK, ADJ_TH, ADJ_TM, ADJ_AH, ADJ_AM, ADJ_S. Outputs are registered Moore decodes: the selected EN is high, the others are 0. CLOCK has all EN=0 and adjust=0.
- Transitions, evaluated on press events in the same cycle:
  - c in CLOCK -> ADJ_TH.
  - c in any ADJ state -> CLOCK.
  - r: TH->TM->AH->AM->S->TH (wraps).
  - l: reverse order, TH->S (wraps).
  - l or r in CLOCK: ignored.
- Simultaneous events:
  - c with l and/or r: c wins, l/r discarded.
  - l with r (no c): both ignored, state held.
- up/down:
  - A u press event in an ADJ state gives up=1 for one cycle; likewise d gives down=1. Registered, so each pulse is 1 cycle after its press event.
  - In CLOCK both are suppressed.
  - u and d in the same cycle: both suppressed.
  - up/down may coincide with a state change. The pulse is gated by the state before the transition. A u press in the same cycle as the c that enters adjust produces no pulse.
  - up and down are never both 1.
- Timeout (TIMEOUT_CYCLES>0):
  - The idle counter runs only in ADJ states and clears on any press event or state change.
  - On reaching TIMEOUT_CYCLES: -> CLOCK next cycle, counter cleared.
  - An event arriving in the same cycle as expiry takes priority; the timeout is discarded.
- Invariant: at most one EN high; adjust = OR of all EN.

Decomposition:
- Shared package `clock_ctrl_pkg`: mode state encoding localparams (CLOCK=0, ADJ_TH=1 ... ADJ_S=5, 3 bits), field order constants, default debounce/timeout values.
- Sub-module `button_debouncer` (SYNC_STAGES, DEBOUNCE_CYCLES; ports clk, rst, btn_in, level, press):
  - Instantiated 5 times.
  - FSM, pulse gating and timeout live in `button_mode_ctrl`.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50):
- Reset then idle 20 cycles -> all outputs 0. Pulse btn_c high for 3 cycles -> no event, state stays CLOCK.
- Hold btn_c from cycle 0 -> ENTH=1 and adjust=1 at the registered output following the press event at cycle 7. Release, re-press btn_c -> back to CLOCK, all 0.
- In ADJ_TH: press btn_r 5 times -> TM, AH, AM, S, TH. Then btn_l once -> S (ENS=1). Then btn_c and btn_r together -> CLOCK.
- In ADJ_TM: hold btn_u 30 cycles -> exactly one up pulse, 1 cycle wide. In CLOCK, press btn_u -> no up. Press btn_u and btn_d together in ADJ -> neither pulses.
- In ADJ_AM with no presses -> returns to CLOCK 51 cycles after the entry edge. A btn_r press event at idle count 30 -> counter restarts and the return is delayed accordingly.
- Assert rst low mid-debounce while in ADJ_AH -> outputs 0 asynchronously. After release, the previously held button needs a full 0->1 debounce before any event.
